// File: rtl/png_chunk_crc_seq.sv
// PNG chunk CRC-32 sequencer: IHDR, IDAT stream and IEND chunks, one 32-bit word per cycle.
// Optional macro PNG_IDAT_SPLIT_EN splits the IDAT stream into chunks of IDAT_MAX_BYTES.
module png_chunk_crc_seq #(
    parameter int unsigned SIZE_W_WD      = 16,
    parameter int unsigned SIZE_H_WD      = 16,
    parameter int unsigned BIT_DEPTH      = 8,
    parameter int unsigned COLOR_TYPE     = 6,
    parameter int unsigned LEN_WD         = 32,
    parameter int unsigned IDAT_MAX_BYTES = 65536
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SIZE_W_WD-1:0] w_i,
    input  logic [SIZE_H_WD-1:0] h_i,
    input  logic                 start_i,
    input  logic                 val_i,
    output logic                 rdy_o,
    input  logic [31:0]          dat_i,
    input  logic [1:0]           num_i,
    input  logic                 lst_i,
    output logic                 crc_val_o,
    output logic [31:0]          crc_o,
    output logic [LEN_WD-1:0]    len_o,
    output logic [1:0]           typ_o,
    output logic                 done_o,
    output logic                 busy_o
);
    localparam int unsigned CRC_WD  = 32;
    localparam int unsigned STEP_WD = 3;
    localparam int unsigned NB_WD   = 3;

    localparam logic [CRC_WD-1:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [CRC_WD-1:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [CRC_WD-1:0] TYP_IHDR = 32'h4948_4452;
    localparam logic [CRC_WD-1:0] TYP_IDAT = 32'h4944_4154;
    localparam logic [CRC_WD-1:0] TYP_IEND = 32'h4945_4E44;
    localparam logic [1:0]        KIND_IHDR = 2'd0;
    localparam logic [1:0]        KIND_IDAT = 2'd1;
    localparam logic [1:0]        KIND_IEND = 2'd2;
    localparam logic [LEN_WD-1:0] IHDR_LEN  = LEN_WD'(13);

    // Elaboration-time guard on the chunk size
    if (((IDAT_MAX_BYTES % 4) != 0) ||
        (longint'(IDAT_MAX_BYTES) >= (longint'(1) <<< (LEN_WD - 1)))) begin : g_bad_cfg
        $error("png_chunk_crc_seq: IDAT_MAX_BYTES out of range");
    end

    typedef enum logic [2:0] {IDLE, HDR, DTYP, DDAT, ETYP} state_t;

    state_t                state_q, state_d;
    logic [STEP_WD-1:0]    step_q, step_d;
    logic [SIZE_W_WD-1:0]  w_q, w_d;
    logic [SIZE_H_WD-1:0]  h_q, h_d;
    logic [CRC_WD-1:0]     crc_q, crc_d;
    logic [LEN_WD-1:0]     byte_q, byte_d;
    logic                  rdy_d, crc_val_d, done_d, busy_d;
    logic [CRC_WD-1:0]     crc_res_d;
    logic [LEN_WD-1:0]     len_d;
    logic [1:0]            typ_d;
    logic [CRC_WD-1:0]     ab_base, ab_word, crc_new;
    logic [NB_WD-1:0]      ab_nb, beat_nb;
    logic [LEN_WD-1:0]     byte_add;
    logic                  beat_acc;

    // Reflected CRC-32 over the leading nbytes of a word, MSB byte first
    function automatic logic [CRC_WD-1:0] crc_word(input logic [CRC_WD-1:0] crc_in,
                                                   input logic [CRC_WD-1:0] word,
                                                   input logic [NB_WD-1:0]  nbytes);
        logic [CRC_WD-1:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (NB_WD'(b) < nbytes) begin
                c = c ^ {24'h00_0000, word[CRC_WD-1-8*b -: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    assign beat_nb  = NB_WD'(num_i) + NB_WD'(1);
    assign beat_acc = val_i & rdy_o;

`ifdef PNG_IDAT_SPLIT_EN
    assign byte_add = byte_q + LEN_WD'(beat_nb);
`else
    logic [LEN_WD:0] byte_sum;
    assign byte_sum = {1'b0, byte_q} + (LEN_WD+1)'(beat_nb);
    assign byte_add = byte_sum[LEN_WD] ? {LEN_WD{1'b1}} : byte_sum[LEN_WD-1:0];
`endif

    // Word, seed and byte count fed to the single CRC engine
    always_comb begin
        ab_base = crc_q;
        ab_word = dat_i;
        ab_nb   = beat_nb;
        case (state_q)
            HDR: begin
                ab_nb = NB_WD'(4);
                case (step_q)
                    3'd0: begin
                        ab_base = CRC_INIT;
                        ab_word = TYP_IHDR;
                    end
                    3'd1:    ab_word = CRC_WD'(w_q);
                    3'd2:    ab_word = CRC_WD'(h_q);
                    3'd3:    ab_word = {8'(BIT_DEPTH), 8'(COLOR_TYPE), 16'h0000};
                    default: begin
                        ab_word = '0;
                        ab_nb   = NB_WD'(1);
                    end
                endcase
            end
            DTYP: begin
                ab_base = CRC_INIT;
                ab_word = TYP_IDAT;
                ab_nb   = NB_WD'(4);
            end
            ETYP: begin
                ab_base = CRC_INIT;
                ab_word = TYP_IEND;
                ab_nb   = NB_WD'(4);
            end
            default: ;
        endcase
    end

    assign crc_new = crc_word(ab_base, ab_word, ab_nb);

    // Next state, datapath and output values
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        w_d       = w_q;
        h_d       = h_q;
        crc_d     = crc_q;
        byte_d    = byte_q;
        crc_val_d = 1'b0;
        done_d    = 1'b0;
        crc_res_d = crc_o;
        len_d     = len_o;
        typ_d     = typ_o;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    w_d     = w_i;
                    h_d     = h_i;
                    step_d  = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                crc_d  = crc_new;
                step_d = step_q + STEP_WD'(1);
                if (step_q == STEP_WD'(4)) begin
                    state_d   = DTYP;
                    crc_val_d = 1'b1;
                    crc_res_d = ~crc_new;
                    len_d     = IHDR_LEN;
                    typ_d     = KIND_IHDR;
                end
            end
            DTYP: begin
                crc_d   = crc_new;
                byte_d  = '0;
                state_d = DDAT;
            end
            DDAT: begin
                if (beat_acc) begin
                    crc_d  = crc_new;
                    byte_d = byte_add;
                    if (lst_i) begin
                        state_d   = ETYP;
                        crc_val_d = 1'b1;
                        crc_res_d = ~crc_new;
                        len_d     = byte_add;
                        typ_d     = KIND_IDAT;
                    end
`ifdef PNG_IDAT_SPLIT_EN
                    else if (byte_q + LEN_WD'(4) == LEN_WD'(IDAT_MAX_BYTES)) begin
                        state_d   = DTYP;
                        crc_val_d = 1'b1;
                        crc_res_d = ~crc_new;
                        len_d     = byte_add;
                        typ_d     = KIND_IDAT;
                    end
`endif
                end
            end
            ETYP: begin
                crc_d     = crc_new;
                state_d   = IDLE;
                crc_val_d = 1'b1;
                done_d    = 1'b1;
                crc_res_d = ~crc_new;
                len_d     = '0;
                typ_d     = KIND_IEND;
            end
            default: state_d = IDLE;
        endcase
        rdy_d  = (state_d == DDAT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            step_q    <= '0;
            w_q       <= '0;
            h_q       <= '0;
            crc_q     <= CRC_INIT;
            byte_q    <= '0;
            rdy_o     <= 1'b0;
            crc_val_o <= 1'b0;
            crc_o     <= '0;
            len_o     <= '0;
            typ_o     <= '0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            w_q       <= w_d;
            h_q       <= h_d;
            crc_q     <= crc_d;
            byte_q    <= byte_d;
            rdy_o     <= rdy_d;
            crc_val_o <= crc_val_d;
            crc_o     <= crc_res_d;
            len_o     <= len_d;
            typ_o     <= typ_d;
            done_o    <= done_d;
            busy_o    <= busy_d;
        end
    end

endmodule

// File: tb/tb_png_chunk_crc_seq.sv
// Self-checking bench for png_chunk_crc_seq: directed and random PNG sequences vs. a byte-level CRC model.
module tb_png_chunk_crc_seq;
    localparam int unsigned LEN_WD = 6;
    localparam int unsigned MAXB   = 8;
    localparam logic [31:0] POLY   = 32'hEDB8_8320;
`ifdef PNG_IDAT_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [1:0]        typ;
        logic [LEN_WD-1:0] len;
        logic [31:0]       crc;
        logic              done;
        int unsigned       cyc;
    } res_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [15:0]       w_i = '0;
    logic [15:0]       h_i = '0;
    logic              start_i = 1'b0;
    logic              val_i = 1'b0;
    logic              rdy_o;
    logic [31:0]       dat_i = '0;
    logic [1:0]        num_i = '0;
    logic              lst_i = 1'b0;
    logic              crc_val_o;
    logic [31:0]       crc_o;
    logic [LEN_WD-1:0] len_o;
    logic [1:0]        typ_o;
    logic              done_o;
    logic              busy_o;

    png_chunk_crc_seq #(
        .SIZE_W_WD(16), .SIZE_H_WD(16), .BIT_DEPTH(8), .COLOR_TYPE(6),
        .LEN_WD(LEN_WD), .IDAT_MAX_BYTES(MAXB)
    ) dut (
        .clk(clk), .rstn(rstn), .w_i(w_i), .h_i(h_i), .start_i(start_i),
        .val_i(val_i), .rdy_o(rdy_o), .dat_i(dat_i), .num_i(num_i), .lst_i(lst_i),
        .crc_val_o(crc_val_o), .crc_o(crc_o), .len_o(len_o), .typ_o(typ_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor, a little after each rising edge
    res_t obs [$];
    res_t mon_r;
    int   stray_done = 0;
    always @(posedge clk) begin
        #1;
        if (crc_val_o === 1'b1) begin
            mon_r.typ  = typ_o;
            mon_r.len  = len_o;
            mon_r.crc  = crc_o;
            mon_r.done = done_o;
            mon_r.cyc  = cyc;
            obs.push_back(mon_r);
        end
        if (done_o === 1'b1 && crc_val_o !== 1'b1) stray_done++;
    end

    int n_cmp = 0;
    int n_err = 0;
    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    // Reference CRC-32: table-driven, byte oriented
    logic [31:0] tab [256];
    function automatic void init_tab();
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
            tab[n] = c;
        end
    endfunction

    function automatic logic [31:0] crc_bytes(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) c = tab[c[7:0] ^ q[i]] ^ (c >> 8);
        return ~c;
    endfunction

    function automatic bq_t be_bytes(input logic [31:0] wd, input int nb);
        bq_t r;
        for (int k = 0; k < nb; k++) r.push_back(wd[31-8*k -: 8]);
        return r;
    endfunction

    function automatic bq_t cat(input bq_t a, input bq_t b);
        bq_t r;
        r = a;
        foreach (b[i]) r.push_back(b[i]);
        return r;
    endfunction

    res_t last_res [$];

    // One full sequence started on the current falling edge; returns at the done_o edge
    task automatic run_seq(input string name, input logic [15:0] w, input logic [15:0] h,
                           input logic [31:0] dq [$], input logic [1:0] lnum, input bit noisy);
        int unsigned c0, acc [$];
        int          n, i, bud, total, st, ln, bi;
        bit          gap, split_prev;
        bq_t         q, all;
        res_t        e [$], ex, r;

        n   = dq.size();
        c0  = cyc;
        w_i = w; h_i = h; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("%s rdy_o low cyc%0d", name, k), 64'(rdy_o), 64'(0));
            chk($sformatf("%s busy_o cyc%0d", name, k), 64'(busy_o), 64'(1));
            if (noisy) begin
                val_i = 1'($urandom); lst_i = 1'($urandom);
                dat_i = $urandom;     num_i = 2'($urandom);
            end
            @(negedge clk);
        end

        i = 0; bud = 0; split_prev = 1'b0;
        while (i < n && bud < 400) begin
            chk($sformatf("%s rdy_o beat%0d", name, i), 64'(rdy_o), 64'(!split_prev));
            gap     = ($urandom_range(0, 3) == 0);
            val_i   = !gap;
            dat_i   = gap ? $urandom : dq[i];
            num_i   = (i == n - 1) ? lnum : 2'd3;
            lst_i   = (i == n - 1) && !gap;
            start_i = noisy && gap;
            if (val_i && rdy_o) begin
                acc.push_back(cyc + 1);
                split_prev = SPLIT && (i != n - 1) && ((((i + 1) * 4) % int'(MAXB)) == 0);
                i++;
            end else begin
                split_prev = 1'b0;
            end
            @(negedge clk);
            bud++;
        end
        val_i = 1'b0; lst_i = 1'b0; start_i = 1'b0;
        chk($sformatf("%s beats accepted", name), 64'(i), 64'(n));

        bud = 0;
        while (done_o !== 1'b1 && bud < 40) begin
            @(negedge clk);
            bud++;
        end
        chk($sformatf("%s done_o", name), 64'(done_o), 64'(1));
        chk($sformatf("%s busy_o at done", name), 64'(busy_o), 64'(0));

        // Expected chunk list from the byte stream
        q = cat(be_bytes(32'h4948_4452, 4), be_bytes(32'(w), 4));
        q = cat(q, be_bytes(32'(h), 4));
        q = cat(q, be_bytes(32'h0806_0000, 4));
        q = cat(q, be_bytes(32'h0, 1));
        ex.typ = 2'd0; ex.len = LEN_WD'(13); ex.crc = crc_bytes(q); ex.done = 1'b0; ex.cyc = c0 + 6;
        e.push_back(ex);
        for (int j = 0; j < n; j++) all = cat(all, be_bytes(dq[j], (j == n - 1) ? int'(lnum) + 1 : 4));
        total = all.size();
        if (SPLIT) begin
            st = 0;
            while (st < total) begin
                ln = (total - st > int'(MAXB)) ? int'(MAXB) : total - st;
                q  = be_bytes(32'h4944_4154, 4);
                for (int k = st; k < st + ln; k++) q.push_back(all[k]);
                bi = (st + ln - 1) / 4;
                ex.typ = 2'd1; ex.len = LEN_WD'(ln); ex.crc = crc_bytes(q); ex.done = 1'b0;
                ex.cyc = (bi < acc.size()) ? acc[bi] : 0;
                e.push_back(ex);
                st += ln;
            end
        end else begin
            q = cat(be_bytes(32'h4944_4154, 4), all);
            ln = (total > (1 << LEN_WD) - 1) ? (1 << LEN_WD) - 1 : total;
            ex.typ = 2'd1; ex.len = LEN_WD'(ln); ex.crc = crc_bytes(q); ex.done = 1'b0;
            ex.cyc = (acc.size() > 0) ? acc[acc.size() - 1] : 0;
            e.push_back(ex);
        end
        ex.typ = 2'd2; ex.len = '0; ex.crc = crc_bytes(be_bytes(32'h4945_4E44, 4)); ex.done = 1'b1;
        ex.cyc = (acc.size() > 0) ? acc[acc.size() - 1] + 1 : 0;
        e.push_back(ex);

        chk($sformatf("%s result count", name), 64'(obs.size()), 64'(e.size()));
        last_res.delete();
        foreach (e[k]) begin
            if (obs.size() > 0) begin
                r = obs.pop_front();
                last_res.push_back(r);
                chk($sformatf("%s r%0d typ", name, k),  64'(r.typ),  64'(e[k].typ));
                chk($sformatf("%s r%0d len", name, k),  64'(r.len),  64'(e[k].len));
                chk($sformatf("%s r%0d crc", name, k),  64'(r.crc),  64'(e[k].crc));
                chk($sformatf("%s r%0d done", name, k), 64'(r.done), 64'(e[k].done));
                chk($sformatf("%s r%0d cycle", name, k), 64'(r.cyc), 64'(e[k].cyc));
            end
        end
        obs.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, " crc_val_o"}, 64'(crc_val_o), 64'(0));
        chk({name, " crc_o"},     64'(crc_o),     64'(0));
        chk({name, " len_o"},     64'(len_o),     64'(0));
        chk({name, " typ_o"},     64'(typ_o),     64'(0));
        chk({name, " done_o"},    64'(done_o),    64'(0));
        chk({name, " busy_o"},    64'(busy_o),    64'(0));
        chk({name, " rdy_o"},     64'(rdy_o),     64'(0));
    endtask

    task automatic idle_hold(input string name);
        repeat (3) @(negedge clk);
        chk({name, " hold crc_val_o"}, 64'(crc_val_o), 64'(0));
        chk({name, " hold done_o"},    64'(done_o),    64'(0));
        chk({name, " hold busy_o"},    64'(busy_o),    64'(0));
        chk({name, " hold typ_o"},     64'(typ_o),     64'(2));
        chk({name, " hold len_o"},     64'(len_o),     64'(0));
        chk({name, " hold crc_o"},     64'(crc_o),     64'(32'hAE42_6082));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dq [$];
        logic [15:0] w, h;
        init_tab();

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // IHDR of a 1x1 image, then a 1-byte IDAT
        dq = '{32'h7800_0000};
        run_seq("t2", 16'd1, 16'd1, dq, 2'd0, 1'b0);
        chk("t1 ihdr crc", 64'((last_res.size() > 0) ? last_res[0].crc : 32'h0), 64'(32'h1F15_C489));
        chk("t2 iend crc", 64'((last_res.size() > 2) ? last_res[2].crc : 32'h0), 64'(32'hAE42_6082));
        idle_hold("t2");

        // Five full beats, then the same stimulus with noise, then four beats back-to-back
        w = 16'($urandom); h = 16'($urandom);
        dq.delete();
        for (int k = 0; k < 5; k++) dq.push_back($urandom);
        run_seq("t3", w, h, dq, 2'd3, 1'b0);
        run_seq("t5", w, h, dq, 2'd3, 1'b1);
        dq.delete();
        for (int k = 0; k < 4; k++) dq.push_back($urandom);
        run_seq("t4", 16'($urandom), 16'($urandom), dq, 2'd3, 1'b0);
        idle_hold("t4");

        // Long stream: exercises the byte counter limit
        dq.delete();
        for (int k = 0; k < 17; k++) dq.push_back($urandom);
        run_seq("long", 16'($urandom), 16'($urandom), dq, 2'd3, 1'b0);

        // Random sequences chained back-to-back
        for (int s = 0; s < 6; s++) begin
            dq.delete();
            for (int k = 0; k < int'($urandom_range(1, 12)); k++) dq.push_back($urandom);
            run_seq($sformatf("rnd%0d", s), 16'($urandom), 16'($urandom), dq, 2'($urandom), 1'(s % 2));
        end
        idle_hold("rnd");

        // Abort mid-IDAT with reset, then rerun the 1-byte case
        start_i = 1'b1; w_i = 16'd7; h_i = 16'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        val_i = 1'b1; dat_i = $urandom; num_i = 2'd3; lst_i = 1'b0;
        @(negedge clk);
        val_i = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_zero("abort");
        chk("abort pulses", 64'(obs.size()), 64'(1));
        repeat (2) @(negedge clk);
        chk_zero("abort held");
        rstn = 1'b1;
        obs.delete();
        @(negedge clk);
        dq = '{32'h7800_0000};
        run_seq("t6", 16'd1, 16'd1, dq, 2'd0, 1'b0);
        chk("t6 ihdr crc", 64'((last_res.size() > 0) ? last_res[0].crc : 32'h0), 64'(32'h1F15_C489));
        idle_hold("t6");

        chk("stray done_o", 64'(stray_done), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
